// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences data stalls, control-hazard waits and
// the single-cycle flush that retires a resolved call/ret/branch hazard.
// Memory back-pressure (ext_stall) overrides everything and freezes the FSM.
module pipe_hazard_ctrl #(
  parameter int MAX_DSTALL   = 4,
  parameter int CTRL_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_hazard,
  input  logic        control_hazard,
  input  logic        call,
  input  logic        ret,
  input  logic        branch,
  input  logic        call_done,
  input  logic        ret_done,
  input  logic        branch_done,
  input  logic        ext_stall,
  output logic        pc_hold,
  output logic        if_id_hold,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        clr_call_haz,
  output logic        clr_ret_haz,
  output logic        clr_branch_haz,
  output logic [15:0] stall_cycles,
  output logic        err
);

  localparam int DW = $clog2(MAX_DSTALL + 1);
  localparam int CW = $clog2(CTRL_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, DSTALL, CWAIT, FLUSH} state_t;

  // One bit per control-transfer type awaiting resolution.
  typedef struct packed {
    logic call;
    logic ret;
    logic branch;
  } haz_t;

  state_t          state, state_nxt;
  haz_t            pend, pend_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [CW-1:0]   ccnt, ccnt_nxt;
  logic            done_lat, done_lat_nxt;
  logic            err_set;
  logic            done_hit;

  // A resolution pulse only counts if its type is actually pending.
  assign done_hit = (call_done & pend.call) | (ret_done & pend.ret) |
                    (branch_done & pend.branch);

  // Next-state and output decode; ext_stall wins, then control, then data.
  always_comb begin
    state_nxt      = state;
    pend_nxt       = pend;
    dcnt_nxt       = dcnt;
    ccnt_nxt       = ccnt;
    done_lat_nxt   = done_lat;
    err_set        = 1'b0;
    pc_hold        = 1'b0;
    if_id_hold     = 1'b0;
    id_ex_bubble   = 1'b0;
    if_id_flush    = 1'b0;
    clr_call_haz   = 1'b0;
    clr_ret_haz    = 1'b0;
    clr_branch_haz = 1'b0;
    if (!rst) begin
      // Reset holds every output low; registers are cleared asynchronously.
    end else if (ext_stall) begin
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
      // Remember a resolution that lands while frozen so it is not lost.
      if (state == CWAIT && done_hit) done_lat_nxt = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (control_hazard) begin
            pend_nxt  = '{call: call, ret: ret, branch: branch};
            ccnt_nxt  = '0;
            state_nxt = CWAIT;
          end else if (data_hazard) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            dcnt_nxt     = DW'(1);
            state_nxt    = DSTALL;
          end
        end
        DSTALL: begin
          if (control_hazard) begin
            pend_nxt  = '{call: call, ret: ret, branch: branch};
            dcnt_nxt  = '0;
            ccnt_nxt  = '0;
            state_nxt = CWAIT;
          end else if (data_hazard) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            // Counter parks at the limit; stalling continues with err raised.
            if (int'(dcnt) >= MAX_DSTALL) err_set = 1'b1;
            else                          dcnt_nxt = dcnt + 1'b1;
          end else begin
            dcnt_nxt  = '0;
            state_nxt = RUN;
          end
        end
        CWAIT: begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          ccnt_nxt    = ccnt + 1'b1;
          if (done_hit || done_lat) begin
            state_nxt = FLUSH;
          end else if (int'(ccnt) + 1 >= CTRL_TIMEOUT) begin
            err_set   = 1'b1;
            state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          if_id_flush    = 1'b1;
          clr_call_haz   = pend.call;
          clr_ret_haz    = pend.ret;
          clr_branch_haz = pend.branch;
          pend_nxt       = '0;
          done_lat_nxt   = 1'b0;
          ccnt_nxt       = '0;
          state_nxt      = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, counters and sticky error; stall counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      pend         <= '0;
      dcnt         <= '0;
      ccnt         <= '0;
      done_lat     <= 1'b0;
      err          <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      dcnt     <= dcnt_nxt;
      ccnt     <= ccnt_nxt;
      done_lat <= done_lat_nxt;
      err      <= err | err_set;
      if (pc_hold && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the stall rules.
module tb_pipe_hazard_ctrl;
  localparam int MAXD = 4;
  localparam int TMO  = 16;

  // Stimulus vector bits: {rst_n, dh, ch, call, ret, branch, cd, rd, bd, es}
  localparam logic [9:0] R    = 10'h200;
  localparam logic [9:0] DH   = 10'h100;
  localparam logic [9:0] CH   = 10'h080;
  localparam logic [9:0] CALL = 10'h040;
  localparam logic [9:0] RET  = 10'h020;
  localparam logic [9:0] BR   = 10'h010;
  localparam logic [9:0] CD   = 10'h008;
  localparam logic [9:0] RD   = 10'h004;
  localparam logic [9:0] BD   = 10'h002;
  localparam logic [9:0] ES   = 10'h001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dh = 1'b0, ch = 1'b0, call = 1'b0, ret = 1'b0, branch = 1'b0;
  logic cd = 1'b0, rd = 1'b0, bd = 1'b0, es = 1'b0;
  logic pc_hold, if_id_hold, id_ex_bubble, if_id_flush;
  logic clr_call_haz, clr_ret_haz, clr_branch_haz, err;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 normal, 1 data stall, 2 awaiting resolution, 3 flush.
  int       mph;
  int       mrun;    // consecutive stall cycles including the current one
  int       mwait;   // waiting cycles including the current one
  bit [2:0] mpend;
  bit       mgot;
  int       mcount;
  bit       merr;
  logic [6:0] eo;      // expected {pc,ifh,bub,flush,clr_call,clr_ret,clr_br}
  logic [6:0] last_outs;
  int       hold_seen;
  int       clr_seen;

  pipe_hazard_ctrl #(.MAX_DSTALL(MAXD), .CTRL_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .data_hazard(dh), .control_hazard(ch),
    .call(call), .ret(ret), .branch(branch),
    .call_done(cd), .ret_done(rd), .branch_done(bd), .ext_stall(es),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .clr_call_haz(clr_call_haz),
    .clr_ret_haz(clr_ret_haz), .clr_branch_haz(clr_branch_haz),
    .stall_cycles(stall_cycles), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mph = 0; mrun = 0; mwait = 0; mpend = '0; mgot = 0; mcount = 0; merr = 0;
  endtask

  // Apply the stall rules for one cycle of the current inputs.
  task automatic model_cycle();
    bit [2:0] done;
    bit hit;
    done = {cd, rd, bd};
    hit  = |(done & mpend);
    eo   = '0;
    if (es) begin
      eo[6] = 1'b1; eo[5] = 1'b1;
      if (mph == 2 && hit) mgot = 1;
    end else begin
      case (mph)
        0: if (ch) begin
             mpend = {call, ret, branch}; mwait = 0; mph = 2;
           end else if (dh) begin
             eo[6:4] = 3'b111; mrun = 1; mph = 1;
           end
        1: if (ch) begin
             mpend = {call, ret, branch}; mrun = 0; mwait = 0; mph = 2;
           end else if (dh) begin
             eo[6:4] = 3'b111; mrun++;
             if (mrun > MAXD) merr = 1;
           end else begin
             mrun = 0; mph = 0;
           end
        2: begin
             eo[6] = 1'b1; eo[3] = 1'b1; mwait++;
             if (hit || mgot) mph = 3;
             else if (mwait >= TMO) begin merr = 1; mph = 3; end
           end
        default: begin
             eo[3] = 1'b1; eo[2:0] = mpend; mpend = '0; mgot = 0; mph = 0;
           end
      endcase
    end
    if (eo[6] && mcount < 65535) mcount++;
  endtask

  // One clock cycle: drive just after the edge, check mid-cycle.
  task automatic cyc(input logic [9:0] v);
    int  snap_cnt;
    bit  snap_err;
    {rst, dh, ch, call, ret, branch, cd, rd, bd, es} = v;
    #3;
    if (!rst) model_reset();
    snap_cnt = mcount;
    snap_err = merr;
    if (rst) model_cycle();
    else     eo = '0;
    last_outs = {pc_hold, if_id_hold, id_ex_bubble, if_id_flush,
                 clr_call_haz, clr_ret_haz, clr_branch_haz};
    if (pc_hold === 1'b1) hold_seen++;
    if (|last_outs[2:0]) clr_seen++;
    chk("outs", 32'(last_outs), 32'(eo));
    chk("stall_cycles", 32'(stall_cycles), 32'(snap_cnt));
    chk("err", 32'(err), 32'(snap_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] v;
    model_reset();
    #1;
    // Reset suppresses the combinational data-stall outputs.
    cyc(DH);
    chk("rst_outs", 32'(last_outs), 32'd0);
    cyc(DH);

    // Four-cycle data stall: no error.
    hold_seen = 0;
    repeat (4) cyc(R | DH);
    cyc(R);
    chk("d4_holds", 32'(hold_seen), 32'd4);
    chk("d4_count", 32'(stall_cycles), 32'd4);
    chk("d4_err", 32'(err), 32'd0);

    // Six-cycle data stall: error raised, stalls continue.
    hold_seen = 0;
    repeat (6) cyc(R | DH);
    chk("d6_holds", 32'(hold_seen), 32'd6);
    chk("d6_err", 32'(err), 32'd1);
    cyc(R);
    cyc(0);

    // Call resolved three cycles after the hazard.
    hold_seen = 0;
    cyc(R | CH | CALL);
    cyc(R); cyc(R); cyc(R | CD);
    cyc(R);
    chk("call_flush", 32'(last_outs), 32'b0001100);
    cyc(R);
    chk("call_run", 32'(last_outs), 32'd0);
    chk("call_holds", 32'(hold_seen), 32'd3);

    // Branch never resolves: timeout error, clear on cycle 17.
    cyc(R | CH | BR);
    repeat (TMO) cyc(R);
    chk("br_err", 32'(err), 32'd1);
    cyc(R);
    chk("br_clr", 32'(last_outs[2:0]), 32'b001);
    cyc(0);

    // Ret resolved during back-pressure.
    cyc(R | CH | RET);
    cyc(R);
    cyc(R | ES | RD);
    cyc(R | ES);
    chk("ret_es_clr", 32'(last_outs[2:0]), 32'd0);
    cyc(R);
    chk("ret_wait_clr", 32'(last_outs[2:0]), 32'd0);
    cyc(R);
    chk("ret_clr", 32'(last_outs[2:0]), 32'b010);

    // Reset in the middle of a wait drops the pending clear.
    cyc(R | CH | CALL);
    cyc(R);
    cyc(0);
    chk("rst_cwait_outs", 32'(last_outs), 32'd0);
    chk("rst_cwait_cnt", 32'(stall_cycles), 32'd0);
    clr_seen = 0;
    repeat (4) cyc(R | CD);
    chk("rst_cwait_noclr", 32'(clr_seen), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      v = '0;
      v[9] = ($urandom_range(0, 199) != 0);
      v[8] = ($urandom_range(0, 9) < 5);
      v[7] = ($urandom_range(0, 9) == 0);
      v[6] = 1'($urandom_range(0, 1));
      v[5] = 1'($urandom_range(0, 1));
      v[4] = 1'($urandom_range(0, 1));
      v[3] = ($urandom_range(0, 9) < 2);
      v[2] = ($urandom_range(0, 9) < 2);
      v[1] = ($urandom_range(0, 9) < 2);
      v[0] = ($urandom_range(0, 9) < 2);
      cyc(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
